// File: rtl/sprite_move_pkg.sv
// sprite_move_pkg: direction codes and the coordinate-step helper shared by the sprite movers.
package sprite_move_pkg;
  localparam logic [2:0] DIR_DEFAULT = 3'b000;
  localparam logic [2:0] DIR_RIGHT   = 3'b001;
  localparam logic [2:0] DIR_DOWN    = 3'b010;
  localparam logic [2:0] DIR_UP      = 3'b011;
  localparam logic [2:0] DIR_LEFT    = 3'b100;
  typedef struct packed {
    logic [31:0] val;
    logic        hit;
  } coord_t;
  // Wide int arithmetic cannot overflow for any legal coordinate width.
  function automatic coord_t next_coord(input int v, input logic dec, input int step,
                                        input int lim, input logic wrap);
    int s;
    coord_t r;
    s = dec ? v - step : v + step;
    r.hit = dec ? (v < step) : (s > lim);
    r.val = !r.hit ? s : wrap ? (dec ? s + lim + 1 : s - lim - 1) : (dec ? 0 : lim);
    return r;
  endfunction
endpackage

// File: rtl/sprite_move_ch.sv
// sprite_move_ch: one sprite channel - direction FSM, X/Y position registers and edge flag.
module sprite_move_ch
  import sprite_move_pkg::*;
#(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int STEP   = 4,
  parameter int WRAP   = 0,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick_i,
  input  logic           left_i,
  input  logic           right_i,
  input  logic           up_i,
  input  logic           down_i,
  input  logic           load_i,
  input  logic [X_W-1:0] load_x_i,
  input  logic [Y_W-1:0] load_y_i,
  output logic [2:0]     dir_o,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o,
  output logic           edge_hit_o
);
  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);
  logic [2:0]     dir_q, dir_d, sel;
  logic [3:0]     req;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           hit_q, hit_d, mv_x, mv_y;
  coord_t         xs, ys;
  logic           unused_bits;
  assign req = {left_i, right_i, up_i, down_i};
  assign sel = left_i ? DIR_LEFT : right_i ? DIR_RIGHT : up_i ? DIR_UP : DIR_DOWN;
  assign mv_x = (dir_q == DIR_LEFT) || (dir_q == DIR_RIGHT);
  assign mv_y = (dir_q == DIR_UP) || (dir_q == DIR_DOWN);
  assign xs = next_coord(int'(x_q), dir_q == DIR_LEFT, STEP, X_MAX, WRAP != 0);
  assign ys = next_coord(int'(y_q), dir_q == DIR_UP, STEP, Y_MAX, WRAP != 0);
  assign unused_bits = ^{xs.val[31:X_W], ys.val[31:Y_W]};
  always_comb begin
    dir_d = (req == 4'b0) ? DIR_DEFAULT : $onehot(req) ? sel :
            (dir_q > DIR_LEFT) ? DIR_DEFAULT : dir_q;
    x_d   = x_q;
    y_d   = y_q;
    hit_d = 1'b0;
    if (load_i) begin
      x_d = (load_x_i > XM) ? XM : load_x_i;
      y_d = (load_y_i > YM) ? YM : load_y_i;
    end else if (frame_tick_i) begin
      x_d   = mv_x ? X_W'(xs.val) : x_q;
      y_d   = mv_y ? Y_W'(ys.val) : y_q;
      hit_d = (mv_x && xs.hit) || (mv_y && ys.hit);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= DIR_DEFAULT;
      x_q   <= X_W'(X_INIT);
      y_q   <= Y_W'(Y_INIT);
      hit_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hit_q <= hit_d;
    end
  end
  assign dir_o      = dir_q;
  assign pos_x_o    = x_q;
  assign pos_y_o    = y_q;
  assign edge_hit_o = hit_q;
endmodule

// File: rtl/sprite_move_ctrl.sv
// sprite_move_ctrl: N_CH independent sprite movers with packed direction/position outputs.
module sprite_move_ctrl
  import sprite_move_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int STEP   = 4,
  parameter int WRAP   = 0,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [N_CH-1:0]     left,
  input  logic [N_CH-1:0]     right,
  input  logic [N_CH-1:0]     up,
  input  logic [N_CH-1:0]     down,
  input  logic [N_CH-1:0]     load,
  input  logic [X_W-1:0]      load_x,
  input  logic [Y_W-1:0]      load_y,
  output logic [3*N_CH-1:0]   dataout,
  output logic [X_W*N_CH-1:0] pos_x,
  output logic [Y_W*N_CH-1:0] pos_y,
  output logic [N_CH-1:0]     edge_hit
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sprite_move_ch #(
      .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP),
      .WRAP(WRAP), .X_INIT(X_INIT), .Y_INIT(Y_INIT)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .frame_tick_i(frame_tick),
      .left_i      (left[i]),
      .right_i     (right[i]),
      .up_i        (up[i]),
      .down_i      (down[i]),
      .load_i      (load[i]),
      .load_x_i    (load_x),
      .load_y_i    (load_y),
      .dir_o       (dataout[3*i+:3]),
      .pos_x_o     (pos_x[X_W*i+:X_W]),
      .pos_y_o     (pos_y[Y_W*i+:Y_W]),
      .edge_hit_o  (edge_hit[i])
    );
  end
endmodule

// File: tb/tb_sprite_move_ctrl.sv
// tb_sprite_move_ctrl: directed scoreboard bench for a clamp and a wrap instance of sprite_move_ctrl.
module tb_sprite_move_ctrl;
  logic       clk = 1'b0;
  logic       reset, frame_tick;
  logic [1:0] left, right, up, down, load;
  logic [9:0] load_x;
  logic [8:0] load_y;
  logic [5:0] dataout, w_dataout;
  logic [19:0] pos_x, w_pos_x;
  logic [17:0] pos_y, w_pos_y;
  logic [1:0] edge_hit, w_edge_hit;
  int vectors = 0;
  int miscompares = 0;
  typedef struct { int sel; logic [31:0] exp; } exp_t;
  exp_t q[$];
  string names[11] = '{"dir0", "x0", "y0", "hit0", "dir1", "x1", "y1", "hit1",
                       "wrap_x0", "wrap_y0", "wrap_hit0"};

  always #5 clk = ~clk;

  sprite_move_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .left(left), .right(right),
    .up(up), .down(down), .load(load), .load_x(load_x), .load_y(load_y),
    .dataout(dataout), .pos_x(pos_x), .pos_y(pos_y), .edge_hit(edge_hit)
  );
  sprite_move_ctrl #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .left(left), .right(right),
    .up(up), .down(down), .load(load), .load_x(load_x), .load_y(load_y),
    .dataout(w_dataout), .pos_x(w_pos_x), .pos_y(w_pos_y), .edge_hit(w_edge_hit)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:  return 32'(dataout[2:0]);
      1:  return 32'(pos_x[9:0]);
      2:  return 32'(pos_y[8:0]);
      3:  return 32'(edge_hit[0]);
      4:  return 32'(dataout[5:3]);
      5:  return 32'(pos_x[19:10]);
      6:  return 32'(pos_y[17:9]);
      7:  return 32'(edge_hit[1]);
      8:  return 32'(w_pos_x[9:0]);
      9:  return 32'(w_pos_y[8:0]);
      default: return 32'(w_edge_hit[0]);
    endcase
  endfunction

  task automatic push(input int sel, input int e);
    q.push_back('{sel, 32'(e)});
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", names[e.sel], o, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    left = '0; right = '0; up = '0; down = '0; load = '0; load_x = '0; load_y = '0;
    repeat (2) @(posedge clk);
    #1;
    push(0, 0); push(1, 320); push(2, 240); push(3, 0);
    push(4, 0); push(5, 320); push(6, 240); push(7, 0);
    push(8, 320); push(9, 240); push(10, 0);
    check();
    reset = 1'b0;
    // right on channel 0, then three frame ticks
    right = 2'b01;
    push(0, 1); push(1, 320); cyc();
    frame_tick = 1'b1;
    push(1, 324); push(3, 0); cyc();
    push(1, 328); cyc();
    push(1, 332); push(2, 240); push(4, 0); push(5, 320); push(6, 240); push(8, 332); cyc();
    // asynchronous reset between edges
    frame_tick = 1'b0;
    reset = 1'b1;
    #2;
    push(0, 0); push(1, 320); push(2, 240); push(3, 0);
    check();
    right = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // clamp at right and top edges
    load = 2'b01; load_x = 10'd638; load_y = 9'd2; right = 2'b01;
    push(1, 638); push(2, 2); push(0, 1); push(3, 0); cyc();
    load = '0; frame_tick = 1'b1;
    push(1, 639); push(3, 1); cyc();
    frame_tick = 1'b0; right = '0; up = 2'b01;
    push(0, 3); push(3, 0); push(1, 639); cyc();
    frame_tick = 1'b1;
    push(2, 0); push(3, 1); cyc();
    push(2, 0); push(3, 1); cyc();
    frame_tick = 1'b0;
    push(3, 0); cyc();
    // wrap instance at right and top edges
    load = 2'b01; load_x = 10'd637; load_y = 9'd1; up = '0; right = 2'b01;
    push(8, 637); push(9, 1); push(0, 1); cyc();
    load = '0; frame_tick = 1'b1;
    push(8, 1); push(10, 1); push(1, 639); push(3, 1); cyc();
    frame_tick = 1'b0; right = '0; up = 2'b01;
    push(0, 3); push(10, 0); push(8, 1); cyc();
    frame_tick = 1'b1;
    push(9, 477); push(10, 1); push(2, 0); push(3, 1); cyc();
    frame_tick = 1'b0;
    push(10, 0); push(9, 477); cyc();
    // conflict holds, release returns to DEFAULT and a tick then does nothing
    up = '0; left = 2'b01;
    push(0, 4); cyc();
    up = 2'b01;
    push(0, 4); cyc();
    left = '0; up = '0;
    push(0, 0); cyc();
    frame_tick = 1'b1;
    push(1, 639); push(2, 0); push(3, 0); push(8, 1); push(9, 477); cyc();
    frame_tick = 1'b0;
    // load beats a simultaneous tick on channel 1, out-of-range X clamped
    right = 2'b10;
    push(4, 1); push(0, 0); cyc();
    load = 2'b10; load_x = 10'd700; load_y = 9'd100; frame_tick = 1'b1;
    push(5, 639); push(6, 100); push(7, 0); push(1, 639); push(3, 0); cyc();
    frame_tick = 1'b0; load = '0; right = '0;
    // landing exactly on the limit is not an edge hit
    load = 2'b01; load_x = 10'd635; load_y = 9'd0; right = 2'b01;
    push(1, 635); push(0, 1); cyc();
    load = '0; frame_tick = 1'b1;
    push(1, 639); push(3, 0); cyc();
    frame_tick = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sprite_move_ctrl.md
Name: sprite_move_ctrl

Overview:
- Parametrised successor to the single-sprite direction FSM.
- Per channel (one channel per sprite), holds a direction state with the same 3-bit encoding as before, plus registered X/Y screen coordinates.
- Coordinates advance by STEP pixels on each frame tick, with clamp or wrap at the screen limits.
- Sits between the debounced button/joystick inputs and the sprite drawing logic.

Parameters:
- N_CH, 2, number of independent sprite channels.
- X_W, 10, X coordinate width.
- Y_W, 9, Y coordinate width.
- X_MAX, 639, largest legal X.
- Y_MAX, 479, largest legal Y.
- STEP, 4, pixels per move; legal range 1 <= STEP <= min(X_MAX, Y_MAX).
- WRAP, 0, edge mode: 0 = clamp, 1 = wrap-around.
- X_INIT, 320, reset X for all channels.
- Y_INIT, 240, reset Y for all channels.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame; moves are applied only on this pulse.
- left  in  N_CH  per-channel left request.
- right  in  N_CH  per-channel right request.
- up  in  N_CH  per-channel up request.
- down  in  N_CH  per-channel down request.
- load  in  N_CH  per-channel position load strobe.
- load_x  in  X_W  load value for X, shared by all channels.
- load_y  in  Y_W  load value for Y, shared by all channels.
- dataout  out  3*N_CH  direction state; channel i occupies bits [3i+2:3i].
- pos_x  out  X_W*N_CH  X coordinate; channel i occupies slice i.
- pos_y  out  Y_W*N_CH  Y coordinate; channel i occupies slice i.
- edge_hit  out  N_CH  one-cycle flag: the last move was clamped or wrapped.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high on port `reset`.
  - While reset is high, every channel holds: dataout = 000 (DEFAULT), pos_x = X_INIT, pos_y = Y_INIT, edge_hit = 0.
  - Reset asserted mid-move discards that move.
- Direction encoding: DEFAULT = 000, RIGHT = 001, DOWN = 010, UP = 011, LEFT = 100. Codes 101–111 are never produced; if reached, they recover to DEFAULT on the next clock.
- Direction FSM, per channel, evaluated every clk edge:
  - Exactly one of left/right/up/down high: go to that state.
  - None high: go to DEFAULT.
  - Two or more high: hold the current state (conflict).
  - Latency is one clock from input to dataout.
- Move, per channel, on a clk edge where frame_tick = 1 and load[i] = 0:
  - The move uses the direction state registered before this edge (the pre-update value of dataout).
  - DEFAULT moves nothing and clears edge_hit.
  - RIGHT changes X by +STEP, LEFT by −STEP, DOWN changes Y by +STEP, UP by −STEP.
  - Position updates exactly one clock after the tick edge.
- Clamp mode (WRAP = 0):
  - x + STEP > X_MAX gives X_MAX.
  - x < STEP gives 0 on a leftward move.
  - Y follows the same rules against Y_MAX.
- Wrap mode (WRAP = 1):
  - x + STEP > X_MAX gives x + STEP − (X_MAX + 1).
  - x < STEP gives x + X_MAX + 1 − STEP.
  - Y follows the same rules.
- Arithmetic: computed at X_W+1 / Y_W+1 bits; no overflow is permitted.
- edge_hit[i]:
  - Set for exactly the one cycle after a move whose result was clamped (value differs from the unclamped sum) or wrapped.
  - A move that lands exactly on a limit without exceeding it does not set edge_hit.
- Load: load[i] = 1 sets pos = (load_x, load_y) on that edge and takes priority over a simultaneous frame_tick move. Out-of-range load values are clamped to X_MAX / Y_MAX. edge_hit is 0 for that cycle. The direction FSM is unaffected by load.
- Channels are fully independent; no cross-channel interaction.

Decomposition:
- Package sprite_move_pkg holds:
  - The direction-code constants (DEFAULT, RIGHT, DOWN, UP, LEFT).
  - A function that computes the next coordinate (value, delta sign, limit, wrap mode) and returns both the new value and the edge flag.
- Sub-module sprite_move_ch: one channel containing the FSM, both coordinate registers and edge_hit.
- The top instantiates sprite_move_ch N_CH times with a generate loop and packs the outputs.

Test Plan:
1. Reset pulse mid-run (channel 0 previously moved) -> dataout = 000, pos = (320, 240), edge_hit = 0 asynchronously, before the next clk edge.
2. Channel 0 right held, 3 frame_ticks, defaults -> dataout = 001; pos_x = 324, 328, 332; pos_y = 240; channel 1 stays at (320, 240).
3. Clamp: load (638, 2), then right for 1 tick and up for 1 tick -> pos_x = 639 with edge_hit = 1; pos_y = 0 with edge_hit = 1. A further up tick keeps 0 with edge_hit = 1.
4. Wrap (WRAP = 1): load (637, 1), then right 1 tick and up 1 tick -> pos_x = 1, pos_y = 477, edge_hit pulses once per move.
5. Conflict and release: in LEFT, assert left+up together -> stays 100. Release all -> 000 next clk, and a subsequent frame_tick leaves the position unchanged.
6. Load vs tick in the same cycle: channel 1 in RIGHT, load = 1 with load_x = 700, load_y = 100, frame_tick = 1 -> pos = (639, 100), edge_hit = 0.
